// File: rtl/arb_pkg.sv
// Shared types and constants for the two-master RAM data-port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam int         RD_LATENCY = 1;
  localparam logic [7:0] HOLD_SAT   = 8'hFF;

  // Consecutive-grant counter saturates instead of wrapping.
  function automatic logic [7:0] hold_inc(input logic [7:0] cnt);
    return (cnt == HOLD_SAT) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin grant with a bounded hold; purely combinational.
module arb_rr2
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       i_req0,
  input  logic       i_req1,
  input  owner_t     i_owner,
  input  logic [7:0] i_hold_cnt,
  output logic [1:0] o_gnt
);

  logic w_hold_done;

  assign w_hold_done = (i_hold_cnt >= 8'(MAX_HOLD));

  always_comb begin
    o_gnt = 2'b00;
    unique case ({i_req1, i_req0})
      2'b01: o_gnt = 2'b01;
      2'b10: o_gnt = 2'b10;
      2'b11: begin
        // Contention: the owner keeps the port until its hold budget is spent.
        case (i_owner)
          OWN_M0:  o_gnt = w_hold_done ? 2'b10 : 2'b01;
          OWN_M1:  o_gnt = w_hold_done ? 2'b01 : 2'b10;
          default: o_gnt = 2'b01;
        endcase
      end
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_port_arbiter.sv
// Shares the RAM data port between the CPU data path (M0) and a secondary master (M1).
// owner | meaning: OWN_NONE idle last cycle, OWN_M0 / OWN_M1 master granted last cycle
module data_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_en,
  input  logic [DATA_W/8-1:0] m0_wen,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_rvalid,
  input  logic                m1_en,
  input  logic [DATA_W/8-1:0] m1_wen,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_rvalid,
  output logic                s_en,
  output logic [DATA_W/8-1:0] s_wen,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W-1:0]   s_rdata
);

  owner_t     r_owner;
  logic [7:0] r_hold_cnt;
  owner_t     r_rtag_q [RD_LATENCY];

  logic [1:0] w_gnt_raw;
  logic [1:0] w_gnt;
  owner_t     w_gnt_owner;
  owner_t     w_rtag;
  logic       w_is_read;

  arb_rr2 #(
    .MAX_HOLD (MAX_HOLD)
  ) u_rr2 (
    .i_req0     (m0_en),
    .i_req1     (m1_en),
    .i_owner    (r_owner),
    .i_hold_cnt (r_hold_cnt),
    .o_gnt      (w_gnt_raw)
  );

  // Reset forces the whole combinational face of the block to zero.
  assign w_gnt = rst ? 2'b00 : w_gnt_raw;

  always_comb begin
    w_gnt_owner = OWN_NONE;
    if (w_gnt[0]) begin
      w_gnt_owner = OWN_M0;
    end else if (w_gnt[1]) begin
      w_gnt_owner = OWN_M1;
    end
  end

  always_comb begin
    s_en    = 1'b0;
    s_wen   = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (w_gnt[0]) begin
      s_en    = 1'b1;
      s_wen   = m0_wen;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (w_gnt[1]) begin
      s_en    = 1'b1;
      s_wen   = m1_wen;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  assign m0_ready  = w_gnt[0];
  assign m1_ready  = w_gnt[1];
  assign w_is_read = s_en && (s_wen == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_hold_cnt <= 8'd0;
    end else if (w_gnt_owner == OWN_NONE) begin
      r_owner    <= OWN_NONE;
      r_hold_cnt <= 8'd0;
    end else if (w_gnt_owner == r_owner) begin
      r_hold_cnt <= hold_inc(r_hold_cnt);
    end else begin
      r_owner    <= w_gnt_owner;
      r_hold_cnt <= 8'd1;
    end
  end

  // Read-return tags ride a RD_LATENCY-deep pipe so returns line up with s_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_rtag_q[i] <= OWN_NONE;
      end
    end else begin
      r_rtag_q[0] <= w_is_read ? w_gnt_owner : OWN_NONE;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_rtag_q[i] <= r_rtag_q[i-1];
      end
    end
  end

  assign w_rtag    = r_rtag_q[RD_LATENCY-1];
  assign m0_rvalid = (w_rtag == OWN_M0);
  assign m1_rvalid = (w_rtag == OWN_M1);
  assign m0_rdata  = (w_rtag == OWN_M0) ? s_rdata : '0;
  assign m1_rdata  = (w_rtag == OWN_M1) ? s_rdata : '0;

endmodule
